// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   UART serial receiver for 8N1-style frames (LSB first, idle high).
//   Rx is oversampled on s_clk (OVERSAMPLE ticks per bit). The start bit is
//   confirmed at mid-bit. DATA_BITS data bits are then shifted in and the stop
//   bit is checked. The received word is presented on Dout together with a
//   one-cycle Rx_done strobe.
//
//   Optional feature macro: UART_RX_MAJORITY_EN
//     defined   -> each sample point uses a 2-of-3 majority of the synchronized
//                  line (current plus two previous values), which rejects
//                  single-tick glitches without adding latency.
//     undefined -> each sample point uses the synchronized line directly.
//
// Ports
//   s_clk      in   1          sampling clock, OVERSAMPLE x baud
//   rst        in   1          asynchronous, active-high reset
//   Rx         in   1          asynchronous serial input
//   Dout       out  DATA_BITS  last received word, held until the next frame ends
//   Rx_done    out  1          one-cycle pulse when the stop bit is sampled
//   Frame_err  out  1          stop bit sampled low; updated with every Rx_done
//   Busy       out  1          high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 s_clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 Rx_done,
    output logic                 Frame_err,
    output logic                 Busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [TICK_W-1:0]      tick_r;
    logic [TICK_W-1:0]      tick_s;
    logic [BIT_W-1:0]       bit_r;
    logic [BIT_W-1:0]       bit_s;
    logic [DATA_BITS-1:0]   shreg_r;
    logic [DATA_BITS-1:0]   shreg_s;
    logic [DATA_BITS-1:0]   dout_r;
    logic [DATA_BITS-1:0]   dout_s;
    logic                   done_r;
    logic                   done_s;
    logic                   ferr_r;
    logic                   ferr_s;
    logic                   busy_r;
    logic                   busy_s;

    logic [1:0]             sync_r;
    logic                   rx_s;
    logic                   rx_prev_r;
    logic                   sample_s;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for Rx plus a one-cycle delayed copy for edge detection
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], Rx};
            rx_prev_r <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 vote used at every sample point
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] hist_r;

    // Two previous synchronized values; together with rx_s they form the vote window
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = majority3(rx_s, hist_r[0], hist_r[1]);
`else
    assign sample_s = rx_s;
`endif

    // Next-state and next-output logic of the receive FSM
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        bit_s   = bit_r;
        shreg_s = shreg_r;
        dout_s  = dout_r;
        done_s  = 1'b0;
        ferr_s  = ferr_r;
        case (state_r)
            IDLE: begin
                tick_s = TICK_ZERO;
                bit_s  = BIT_ZERO;
                // Only a high-to-low transition arms a frame, so a held-low
                // line (break) cannot restart reception.
                if (!rx_s && rx_prev_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_r == TICK_HALF) begin
                    tick_s = TICK_ZERO;
                    bit_s  = BIT_ZERO;
                    if (!sample_s) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            DATA: begin
                if (tick_r == TICK_LAST) begin
                    tick_s  = TICK_ZERO;
                    shreg_s = {sample_s, shreg_r[DATA_BITS-1:1]};
                    bit_s   = bit_r + BIT_ONE;
                    if (bit_r == BIT_LAST) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            STOP: begin
                if (tick_r == TICK_LAST) begin
                    tick_s  = TICK_ZERO;
                    dout_s  = shreg_r;
                    done_s  = 1'b1;
                    ferr_s  = ~sample_s;
                    state_s = IDLE;
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                tick_s  = TICK_ZERO;
                bit_s   = BIT_ZERO;
            end
        endcase
        // Busy is registered from the next state so it tracks state != IDLE exactly
        busy_s = (state_s != IDLE);
    end

    // FSM state, counters, shift register and registered outputs
    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            shreg_r <= {DATA_BITS{1'b0}};
            dout_r  <= {DATA_BITS{1'b0}};
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            done_r  <= done_s;
            ferr_r  <= ferr_s;
            busy_r  <= busy_s;
        end
    end

    assign Dout      = dout_r;
    assign Rx_done   = done_r;
    assign Frame_err = ferr_r;
    assign Busy      = busy_r;

endmodule
